// File: rtl/regfile_dump_reader_if.sv
// Beat stream from the register-file dump reader: {address, data} under valid/ready.
// The master is the dump reader; the slave is the trace or bench consumer.
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              outValid;
    logic              outReady;
    logic [ADDR_W-1:0] outAddr;
    logic [DATA_W-1:0] outData;

    modport master (output outValid, output outAddr, output outData, input outReady);
    modport slave  (input outValid, input outAddr, input outData, output outReady);
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a register range on start and streams {addr,data} beats; REGDUMP_SKIP_ZERO_EN drops r0.
// Latency: start to first outValid is 2 cycles; at most one beat per 2 cycles.
// Backpressure: a beat is held stable in HOLD until outReady; start is ignored while busy.
module regfile_dump_reader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int RF_ADDR_W = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    startAddr,
    input  logic [ADDR_W:0]      count,
    output logic [RF_ADDR_W-1:0] rfAddr,
    input  logic [DATA_W-1:0]    rfData,
    regfile_dump_reader_if.master dump,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, READ, HOLD, FIN} state_t;

    state_t             state;
    state_t             stateNxt;
    logic [ADDR_W-1:0]  cur;
    logic [ADDR_W:0]    rem;
    logic [ADDR_W-1:0]  lastAddr;
    logic               outValidQ;
    logic [ADDR_W-1:0]  outAddrQ;
    logic [DATA_W-1:0]  outDataQ;
    logic               skipZero;
    logic               remIsOne;
    logic [ADDR_W-1:0]  addrSel;

`ifdef REGDUMP_SKIP_ZERO_EN
    // r0 is hardwired zero, so its address is consumed without producing a beat.
    assign skipZero = (cur == '0);
`else
    assign skipZero = 1'b0;
`endif

    assign remIsOne = (rem == (ADDR_W+1)'(1));

    // The read port sees cur only while reading; elsewhere it parks on the last address read.
    assign addrSel = (state == READ) ? cur : lastAddr;
    assign rfAddr  = {{(RF_ADDR_W-ADDR_W){1'b0}}, addrSel};

    assign dump.outValid = outValidQ;
    assign dump.outAddr  = outAddrQ;
    assign dump.outData  = outDataQ;
    assign busy          = (state != IDLE);
    assign done          = (state == FIN);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNxt = (count == '0) ? FIN : READ;
                end
            end
            READ: begin
                if (skipZero) begin
                    stateNxt = remIsOne ? FIN : READ;
                end else begin
                    stateNxt = HOLD;
                end
            end
            HOLD: begin
                if (dump.outReady) begin
                    stateNxt = remIsOne ? FIN : READ;
                end
            end
            FIN: begin
                stateNxt = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur       <= '0;
            rem       <= '0;
            lastAddr  <= '0;
            outValidQ <= 1'b0;
            outAddrQ  <= '0;
            outDataQ  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && (count != '0)) begin
                        cur <= startAddr;
                        rem <= count;
                    end
                end
                READ: begin
                    lastAddr <= cur;
                    if (skipZero) begin
                        cur <= cur + 1'b1;
                        rem <= rem - 1'b1;
                    end else begin
                        outDataQ  <= rfData;
                        outAddrQ  <= cur;
                        outValidQ <= 1'b1;
                    end
                end
                HOLD: begin
                    if (dump.outReady) begin
                        outValidQ <= 1'b0;
                        cur       <= cur + 1'b1;
                        rem       <= rem - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a behavioural register array feeds rfData, and expected beats
// come from a queue built by walking the requested address range.
module tb_regfile_dump_reader;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start;
    logic [4:0]  startAddr;
    logic [5:0]  count;
    logic [31:0] rfAddr;
    logic [31:0] rfData;
    logic        busy;
    logic        done;
    logic [31:0] rf [32];

    int nCmp = 0;
    int nErr = 0;

    regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) dump ();

    regfile_dump_reader #(.DATA_W(32), .ADDR_W(5), .RF_ADDR_W(32)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .startAddr (startAddr),
        .count     (count),
        .rfAddr    (rfAddr),
        .rfData    (rfData),
        .dump      (dump.master),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    assign rfData = rf[rfAddr[4:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete dump; the expected beat list is the address range walked modulo 32.
    task automatic runDump(input int sa, input int cnt, input int readyPct, input int stallFirst,
                           input bit pokeBusy, input bit pokeFin, input bit checkTiming);
        int          expA[$];
        logic [31:0] expD[$];
        int          skips = 0;
        int          lead = 0;
        int          beats;
        int          cyc = 0;
        int          doneCnt = 0;
        int          doneCyc = -1;
        int          firstValid = -1;
        int          stalled = 0;
        int          got = 0;
        bit          rdy;
        bit          prevStall = 0;
        bit          fin = 0;
        for (int i = 0; i < cnt; i++) begin
            int a;
            a = (sa + i) % 32;
`ifdef REGDUMP_SKIP_ZERO_EN
            if (a == 0) begin
                skips++;
                if (expA.size() == 0) lead++;
                continue;
            end
`endif
            expA.push_back(a);
            expD.push_back(rf[a]);
        end
        beats = expA.size();

        @(negedge CLK);
        start     = 1'b1;
        startAddr = sa[4:0];
        count     = cnt[5:0];
        while (!fin && cyc < 600) begin
            @(negedge CLK);
            cyc++;
            start = 1'b0;
            if (pokeBusy && cyc == 3) begin
                start     = 1'b1;
                startAddr = 5'd7;
                count     = 6'd2;
            end
            check("busy_during", busy, 1);
            if (prevStall) check("stall_hold_valid", dump.outValid, 1);
            if (stallFirst > 0 && got == 0) rdy = (stalled >= stallFirst);
            else rdy = ($urandom_range(99) < readyPct);
            dump.outReady = rdy;
            prevStall = 1'b0;
            if (dump.outValid) begin
                if (firstValid < 0) firstValid = cyc;
                if (expA.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    check("beat_addr", dump.outAddr, expA[0]);
                    check("beat_data", dump.outData, expD[0]);
                end
                if (rdy) begin
                    if (expA.size() != 0) begin
                        void'(expA.pop_front());
                        void'(expD.pop_front());
                    end
                    got++;
                end else begin
                    stalled++;
                    prevStall = 1'b1;
                end
            end
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
                fin     = 1'b1;
                if (pokeFin) begin
                    start     = 1'b1;
                    startAddr = 5'd3;
                    count     = 6'd4;
                end
            end
        end
        if (!fin) check("timeout", 0, 1);
        @(negedge CLK);
        start = 1'b0;
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        check("valid_after", dump.outValid, 0);
        check("beat_count", got, beats);
        check("done_count", doneCnt, 1);
        if (checkTiming) begin
            check("done_cycle", doneCyc, 2 * beats + skips + 1);
            if (beats > 0) check("first_valid", firstValid, 2 + lead);
        end
    endtask

    initial begin
        int g;
        int k;
        RST_N         = 1'b1;
        start         = 1'b0;
        startAddr     = '0;
        count         = '0;
        dump.outReady = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;

        #2 RST_N = 1'b0;
        #1;
        check("rst_rfAddr", rfAddr, 0);
        check("rst_outValid", dump.outValid, 0);
        check("rst_outAddr", dump.outAddr, 0);
        check("rst_outData", dump.outData, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        rf[1] = 32'h11111111; rf[2] = 32'h22222222; rf[3] = 32'h33333333;
        runDump(1, 3, 100, 0, 0, 0, 1);

        rf[30] = 32'hA5A5_3030; rf[31] = 32'h5A5A_3131; rf[0] = 32'h0; rf[1] = 32'hC0DE_0001;
        runDump(30, 4, 100, 0, 0, 0, 1);

        runDump(5, 3, 100, 5, 0, 0, 0);

        runDump(9, 0, 100, 0, 0, 0, 1);
        runDump(12, 8, 100, 0, 1, 1, 1);

        // Reset while the second beat of a four-beat dump is being offered.
        @(negedge CLK);
        start = 1'b1; startAddr = 5'd20; count = 6'd4; dump.outReady = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        g = 0;
        for (k = 0; k < 20; k++) begin
            if (dump.outValid) begin
                if (g == 1) break;
                g++;
            end
            @(negedge CLK);
        end
        check("rst_reach_hold", k < 20, 1);
        dump.outReady = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst_outValid", dump.outValid, 0);
        check("mid_rst_outAddr", dump.outAddr, 0);
        check("mid_rst_outData", dump.outData, 0);
        check("mid_rst_rfAddr", rfAddr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end
        runDump(0, 2, 100, 0, 0, 0, 1);

        rf[31] = 32'h3131_FFFF; rf[0] = 32'h0; rf[1] = 32'h0101_0101;
        runDump(31, 3, 100, 0, 0, 0, 1);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            runDump($urandom_range(31), $urandom_range(32), $urandom_range(100, 30), 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
